// File: rtl/clock_ready_generator_pkg.sv
// -----------------------------------------------------------------------------
// clock_ready_generator_pkg
//
// Shared constants and width helpers for the 8284A-style clock/ready generator
// and for any block that reuses its CPU clock phase counter.
// -----------------------------------------------------------------------------
package clock_ready_generator_pkg;

    // Legal parameter ceilings.
    localparam int CPU_CLOCK_DIVIDE_MAX = 16;
    localparam int IO_WAIT_STATES_MAX   = 7;
    localparam int RESET_HOLD_MAX       = 255;

    // Bits needed to hold values 0..max_value. Never returns less than 1, so a
    // zero maximum still yields a legal vector.
    function automatic int counter_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    // Hold counter counts down from RESET_HOLD.
    function automatic int hold_counter_width(input int reset_hold);
        return counter_width(reset_hold);
    endfunction

    // Wait counter counts down from IO_WAIT_STATES.
    function automatic int wait_counter_width(input int wait_states);
        return counter_width(wait_states);
    endfunction

    // Phase counter spans 0..3*divide-1; 3*divide is never a power of two, so
    // $clog2 of the period always covers the last phase.
    function automatic int phase_counter_width(input int divide);
        return $clog2(3 * divide);
    endfunction

endpackage : clock_ready_generator_pkg

// File: rtl/cpu_clock_phase_counter.sv
// -----------------------------------------------------------------------------
// cpu_clock_phase_counter
//
// Divides the system clock by 3*DIVIDE into a 33 %-duty CPU clock and decodes
// the one-cycle enable strobes that mark its rising and falling edges. Shared
// with the video timing path.
//
// Ports
//   clock_i              system clock
//   reset_i              synchronous, active-high reset
//   cpu_clock_o          registered CPU clock level (high for phases 2D..3D-1)
//   cpu_clock_posedge_o  high in the cycle whose ending edge raises cpu_clock_o
//   cpu_clock_negedge_o  high in the cycle whose ending edge drops cpu_clock_o
// -----------------------------------------------------------------------------
module cpu_clock_phase_counter
    import clock_ready_generator_pkg::*;
#(
    parameter int DIVIDE = 3
) (
    input  logic clock_i,
    input  logic reset_i,
    output logic cpu_clock_o,
    output logic cpu_clock_posedge_o,
    output logic cpu_clock_negedge_o
);

    localparam int PW = phase_counter_width(DIVIDE);

    localparam logic [PW-1:0] LAST_PHASE = PW'(3 * DIVIDE - 1);
    localparam logic [PW-1:0] RISE_PHASE = PW'(2 * DIVIDE - 1);
    localparam logic [PW-1:0] HIGH_START = PW'(2 * DIVIDE);

    logic [PW-1:0] phase_q, phase_d;
    logic          cpu_clock_q;

    assign phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            phase_q     <= '0;
            cpu_clock_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            // Registered from the next phase so the level lines up with the
            // phase it describes, not one cycle late.
            cpu_clock_q <= (phase_d >= HIGH_START);
        end
    end

    assign cpu_clock_o         = cpu_clock_q;
    assign cpu_clock_posedge_o = (phase_q == RISE_PHASE);
    assign cpu_clock_negedge_o = (phase_q == LAST_PHASE);

endmodule : cpu_clock_phase_counter

// File: rtl/clock_ready_generator.sv
// -----------------------------------------------------------------------------
// clock_ready_generator
//
// Cycle-based 8284A equivalent: CPU clock and edge strobes, peripheral clock,
// synchronized CPU reset with hold-off, and READY with fixed I/O wait states.
//
// Ports
//   clock              system clock (only clock)
//   reset              synchronous, active-high reset
//   reset_request      system reset request (power-on / keyboard), active-high
//   external_ready     ready from slow peripherals, active-high
//   IOR_N, IOW_N       I/O command strobes from the bus arbiter, active-low
//   cpu_clock          CPU clock level
//   cpu_clock_posedge  strobe: cpu_clock rises at the end of this cycle
//   cpu_clock_negedge  strobe: cpu_clock falls at the end of this cycle
//   peripheral_clock   cpu_clock divided by two
//   cpu_reset          reset to the CPU, active-high
//   READY              ready to the CPU
// -----------------------------------------------------------------------------
module clock_ready_generator
    import clock_ready_generator_pkg::*;
#(
    parameter int CPU_CLOCK_DIVIDE = 3,
    parameter int IO_WAIT_STATES   = 1,
    parameter int RESET_HOLD       = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic reset_request,
    input  logic external_ready,
    input  logic IOR_N,
    input  logic IOW_N,
    output logic cpu_clock,
    output logic cpu_clock_posedge,
    output logic cpu_clock_negedge,
    output logic peripheral_clock,
    output logic cpu_reset,
    output logic READY
);

    localparam int HW = hold_counter_width(RESET_HOLD);
    localparam int WW = wait_counter_width(IO_WAIT_STATES_MAX);

    localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(IO_WAIT_STATES);

    logic          pos_strobe, neg_strobe;
    logic          io_cmd, cmd_edge;

    logic [HW-1:0] hold_q, hold_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          io_cmd_q;
    logic          rdy1_q;
    logic          ready_q;
    logic          cpu_reset_q;
    logic          peripheral_clock_q;

    cpu_clock_phase_counter #(
        .DIVIDE (CPU_CLOCK_DIVIDE)
    ) u_phase (
        .clock_i             (clock),
        .reset_i             (reset),
        .cpu_clock_o         (cpu_clock),
        .cpu_clock_posedge_o (pos_strobe),
        .cpu_clock_negedge_o (neg_strobe)
    );

    assign io_cmd   = ~IOR_N | ~IOW_N;
    // Only a 0->1 change between consecutive posedge samples counts, so a
    // command held across many CPU clocks inserts its wait states once.
    assign cmd_edge = pos_strobe & io_cmd & ~io_cmd_q;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        hold_d = hold_q;
        if (reset_request) begin
            hold_d = HOLD_LOAD;
        end else if (neg_strobe && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // Load and decrement never coincide: the strobes are mutually exclusive.
    always_comb begin
        wait_d = wait_q;
        if (cmd_edge) begin
            wait_d = WAIT_LOAD;
        end else if (neg_strobe && (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q             <= HOLD_LOAD;
            wait_q             <= '0;
            io_cmd_q           <= 1'b0;
            rdy1_q             <= 1'b0;
            ready_q            <= 1'b0;
            cpu_reset_q        <= 1'b1;
            peripheral_clock_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            wait_q <= wait_d;

            if (pos_strobe) begin
                io_cmd_q <= io_cmd;
                rdy1_q   <= external_ready;
            end

            if (neg_strobe) begin
                peripheral_clock_q <= ~peripheral_clock_q;
                // Uses the post-decrement hold so cpu_reset drops on the
                // RESET_HOLD-th negedge strobe after the request releases.
                cpu_reset_q        <= (hold_d != '0) | reset_request;
                // The wait count as loaded at the preceding posedge is what
                // gates READY; it is decremented in the same cycle.
                ready_q            <= rdy1_q & (wait_q == '0);
            end
        end
    end

    assign cpu_clock_posedge = pos_strobe;
    assign cpu_clock_negedge = neg_strobe;
    assign peripheral_clock  = peripheral_clock_q;
    assign cpu_reset         = cpu_reset_q;
    assign READY             = ready_q;

endmodule : clock_ready_generator

// File: doc/clock_ready_generator.md
# clock_ready_generator

Cycle-based equivalent of the 8284A clock generator for KFPCJr, sitting directly upstream of the bus arbiter. It divides the system `clock` into a 33 %-duty CPU clock, produces the one-cycle `cpu_clock_posedge`/`cpu_clock_negedge` enable strobes used by the bus arbiter and CPU core, and derives the peripheral clock. It also generates the synchronized CPU reset and a READY line with fixed I/O wait-state insertion.

## Interface
- `CPU_CLOCK_DIVIDE`, 3, system clocks per third of a CPU clock period; legal range is 1 to 16.
- `IO_WAIT_STATES`, 1, wait states inserted on every I/O command; legal range is 0 to 7.
- `RESET_HOLD`, 4, number of CPU clock periods `cpu_reset` stays asserted after the reset source releases; legal range is 1 to 255.
- `clock` in 1: the only clock.
- `reset` in 1: **synchronous, active-high**.
- `reset_request` in 1: synchronous system reset request (power-on or keyboard); active-high.
- `external_ready` in 1: synchronous ready from slow peripherals; active-high.
- `IOR_N` in 1, `IOW_N` in 1: I/O command strobes from the bus arbiter; active-low.
- `cpu_clock` out 1: CPU clock level.
- `cpu_clock_posedge` out 1: one-cycle strobe; `cpu_clock` rises on the clock edge ending it.
- `cpu_clock_negedge` out 1: one-cycle strobe; `cpu_clock` falls on the clock edge ending it.
- `peripheral_clock` out 1: `cpu_clock` divided by 2.
- `cpu_reset` out 1: reset to the CPU; active-high.
- `READY` out 1: ready to the CPU.

## Operation
- Phase counter `p` counts 0 to 3·D−1 and wraps, where D is `CPU_CLOCK_DIVIDE`.
- The registered `cpu_clock` is 1 exactly while `p` is in the range 2D to 3D−1, so it is high for 1/3 of the period.
- `cpu_clock_posedge` is asserted while `p` equals 2D−1.
- `cpu_clock_negedge` is asserted while `p` equals 3D−1.
- Both strobes are combinational decodes of `p`; they are never asserted in the same cycle.
- `peripheral_clock` toggles on every cycle in which `cpu_clock_negedge` is asserted.
- Reset sequencer:
  - The hold counter is loaded with `RESET_HOLD` while `reset_request` is high.
  - It decrements on each `cpu_clock_negedge` while nonzero.
  - `cpu_reset` is registered. It updates only on `cpu_clock_negedge` cycles and takes the value (counter ≠ 0, or `reset_request`).
- Wait-state logic:
  - `io_cmd` is defined as `~IOR_N | ~IOW_N`.
  - `io_cmd` is sampled into `io_cmd_q` on each `cpu_clock_posedge`.
  - A rising edge (`io_cmd` = 1 and `io_cmd_q` = 0 at a posedge strobe) loads the wait counter with `IO_WAIT_STATES`.
  - Otherwise the wait counter decrements on each `cpu_clock_negedge` while nonzero.
- READY synchronizer, two stages as in 8284 type-1 synchronization:
  - Stage 1: `rdy1` ← `external_ready` on `cpu_clock_posedge`.
  - Stage 2: `READY` ← `rdy1` & (wait counter == 0) on `cpu_clock_negedge`.
  - When a load occurs, the counter value after the load is what is evaluated.
- Boundary conditions:
  - With `IO_WAIT_STATES` = 0, READY is unaffected by commands.
  - A new command edge while the wait counter is nonzero reloads the counter.
  - A command held across several posedges counts as one edge.
  - A command released mid-count does not clear the counter.
  - `reset_request` asserted while `cpu_reset` is already deasserted reasserts `cpu_reset` at the next negedge strobe and restarts the hold.

## Timing
- Reset values: `p` = 0, `cpu_clock` = 0, both strobes = 0 (`p` = 0 is not a strobe phase), `peripheral_clock` = 0, `cpu_reset` = 1, hold counter = `RESET_HOLD`, `READY` = 0, `rdy1` = 0, wait counter = 0, `io_cmd_q` = 0.
- `reset` has priority over every other input, including mid-count.
- The CPU clock period is 3D system clocks. The first posedge strobe occurs at cycle 2D−1 after reset release.
- Latency from `external_ready` to `READY` is one posedge strobe followed by the next negedge strobe, i.e. D+1 to 4D system clocks.
- Inputs are sampled only in strobe cycles; input values between strobes are ignored.

## Structure
- Package `clock_ready_generator_pkg` contains:
  - width functions for the hold and wait counters (`$clog2` of the maximum value + 1);
  - parameter legality constants (`CPU_CLOCK_DIVIDE_MAX` = 16, `IO_WAIT_STATES_MAX` = 7).
- Sub-module `cpu_clock_phase_counter` contains the phase counter, `cpu_clock`, and the strobe decode, parameterized by D. It is reused by the video timing path.
- Reset sequencer, wait counter and READY synchronizer are in the top module.

## Test plan
- D=1, reset released at cycle 0: `cpu_clock` pattern is 0,0,1 repeating; posedge strobe at cycles 1, 4, 7; negedge strobe at cycles 2, 5, 8; `peripheral_clock` toggles after cycles 2, 5, 8.
- D=3: `cpu_clock` is low 6 cycles and high 3 cycles; exactly one posedge and one negedge strobe per 9 cycles, never coincident.
- `RESET_HOLD`=4, `reset_request` held high for 2 µs and then dropped: `cpu_reset` falls exactly at the 4th negedge strobe after the drop, coincident with `cpu_clock` falling.
- `external_ready`=1, `IOR_N` falls before a posedge strobe, `IO_WAIT_STATES`=1: `READY` is 0 for exactly one negedge sample, then returns to 1.
- `external_ready` held 0 for 3 CPU clocks: `READY` low for 3 negedge samples, rising on the negedge after the posedge that sees 1; `IOW_N` held low for 5 CPU clocks inserts only one wait.
- `reset` asserted mid wait-count and mid hold: all outputs return to their reset values on the next clock; `cpu_reset` = 1 and `READY` = 0.
